// File: rtl/memacc_pkg.sv
// rtl/memacc_pkg.sv - memory-stage op encodings, FSM states and bus size helpers
package memacc_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic op_is_store(mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] op_size(mem_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
            default:              return SIZE_WORD;
        endcase
    endfunction

    function automatic logic op_aligned(mem_op_t op, logic [1:0] addr_lo);
        case (op_size(op))
            SIZE_HALF: return ~addr_lo[0];
            SIZE_WORD: return addr_lo == 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

    // The bus picks the active lanes from d_addr, so store data is copied to every lane.
    function automatic logic [31:0] store_lanes(mem_op_t op, logic [31:0] wdata);
        case (op_size(op))
            SIZE_BYTE: return {4{wdata[7:0]}};
            SIZE_HALF: return {2{wdata[15:0]}};
            default:   return wdata;
        endcase
    endfunction

endpackage

// File: rtl/memacc_if.sv
// rtl/memacc_if.sv - data-bus request/response signals between memacc and memory
interface memacc_if;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    modport master (
        output d_req, d_wr, d_size, d_addr, d_wdata,
        input  d_addr_ok, d_data_ok, d_rdata
    );

    modport slave (
        input  d_req, d_wr, d_size, d_addr, d_wdata,
        output d_addr_ok, d_data_ok, d_rdata
    );
endinterface

// File: rtl/memacc_ldext.sv
// rtl/memacc_ldext.sv - load lane select and sign/zero extension
module ldext
    import memacc_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  mem_op_t     i_op,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr, 3'b000} +: 8];
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_data = '0;
        case (i_op)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'd0, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'd0, w_half};
            OP_LW:   o_data = i_rdata;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/memacc.sv
// rtl/memacc.sv - memory-stage access unit: alignment check, bus handshake, load extend
module memacc
    import memacc_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  mem_op_t     in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_regf,
    input  logic        flush,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [4:0]  out_regf,
    output logic        out_adel,
    output logic        out_ades,
    output logic        bus_err,
    memacc_if.master    bus
);

    state_t      r_state;
    state_t      w_state_nxt;
    mem_op_t     r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [4:0]  r_regf;
    logic [31:0] r_result;
    logic        r_adel;
    logic        r_ades;
    logic        r_berr;
    logic        r_flushed;
    logic [31:0] r_cnt;

    logic        w_accept;
    logic        w_aligned;
    logic        w_is_store;
    logic        w_capture;
    logic        w_timeout;
    logic        w_expired;
    logic        w_drop;
    logic [31:0] w_ld_data;

    ldext u_ldext (
        .i_rdata (bus.d_rdata),
        .i_addr  (r_addr[1:0]),
        .i_op    (r_op),
        .o_data  (w_ld_data)
    );

    assign w_aligned  = op_aligned(in_op, in_addr[1:0]);
    assign w_is_store = op_is_store(in_op);
    assign w_expired  = (BUS_TIMEOUT != 0) && (r_cnt == 32'(BUS_TIMEOUT - 1));
    assign w_drop     = r_flushed || flush;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_aligned ? S_ADDR : S_DONE;
                end
            end
            S_ADDR: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.d_addr_ok) begin
                    w_state_nxt = S_DATA;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DATA: begin
                // A flushed op still waits for its data so the bus is never left mid-transfer.
                if (bus.d_data_ok) begin
                    w_capture   = 1'b1;
                    w_state_nxt = w_drop ? S_IDLE : S_DONE;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = w_drop ? S_IDLE : S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= OP_LB;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wr      <= 1'b0;
            r_size    <= SIZE_BYTE;
            r_regf    <= '0;
            r_result  <= '0;
            r_adel    <= 1'b0;
            r_ades    <= 1'b0;
            r_berr    <= 1'b0;
            r_flushed <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= in_op;
                r_addr    <= in_addr;
                r_wdata   <= store_lanes(in_op, in_wdata);
                r_wr      <= w_is_store;
                r_size    <= op_size(in_op);
                r_regf    <= (w_aligned && !w_is_store) ? in_regf : 5'd0;
                r_adel    <= !w_aligned && !w_is_store;
                r_ades    <= !w_aligned && w_is_store;
                r_berr    <= 1'b0;
                r_result  <= '0;
                r_flushed <= 1'b0;
            end
            if (w_capture) begin
                r_result <= r_wr ? 32'd0 : w_ld_data;
            end
            if (w_timeout) begin
                r_berr <= 1'b1;
            end
            if (r_state == S_DATA && flush) begin
                r_flushed <= 1'b1;
            end
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_ADDR || r_state == S_DATA) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    // Gating with rst_n keeps stall low while reset is held even if in_valid is high.
    assign stall = rst_n && ((r_state == S_IDLE && in_valid && !flush) ||
                             r_state == S_ADDR || r_state == S_DATA);

    assign out_valid = (r_state == S_DONE);
    assign out_data  = out_valid ? r_result : 32'd0;
    assign out_regf  = out_valid ? r_regf : 5'd0;
    assign out_adel  = out_valid && r_adel;
    assign out_ades  = out_valid && r_ades;
    assign bus_err   = out_valid && r_berr;

    assign bus.d_req   = (r_state == S_ADDR);
    assign bus.d_wr    = r_wr;
    assign bus.d_size  = r_size;
    assign bus.d_addr  = r_addr;
    assign bus.d_wdata = r_wdata;

endmodule

// File: tb/tb_memacc.sv
// tb/tb_memacc.sv - randomized self-checking bench for memacc against a behavioural model
module tb_memacc;
    import memacc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    mem_op_t     in_op = OP_LB;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [4:0]  in_regf = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_regf;
    logic        out_adel;
    logic        out_ades;
    logic        bus_err;

    int n_chk = 0;
    int n_fail = 0;

    memacc_if bus ();

    memacc #(.BUS_TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_regf   (in_regf),
        .flush     (flush),
        .stall     (stall),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_regf  (out_regf),
        .out_adel  (out_adel),
        .out_ades  (out_ades),
        .bus_err   (bus_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int op_bytes(mem_op_t op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic logic op_store(mem_op_t op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic [31:0] model_load(mem_op_t op, logic [31:0] addr, logic [31:0] rdata);
        int n;
        logic [31:0] v;
        logic [31:0] mask;
        n = op_bytes(op);
        if (n == 4) return rdata;
        mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (rdata >> (8 * (addr % 4))) & mask;
        if ((op == OP_LB || op == OP_LH) && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] regf, input int aw, input int dw, input logic [31:0] rdata);
        int n, cyc, acnt, dcnt, nreq, exp_lat;
        logic al, st, done, phase;
        logic [31:0] exp_data, exp_wd;
        logic [4:0] exp_regf;
        n  = op_bytes(op);
        st = op_store(op);
        al = (addr % n) == 0;
        exp_lat  = al ? 3 + aw + dw : 1;
        exp_data = (al && !st) ? model_load(op, addr, rdata) : 32'd0;
        exp_regf = (al && !st) ? regf : 5'd0;
        exp_wd   = (n == 1) ? {24'd0, wdata[7:0]} * 32'h0101_0101 :
                   (n == 2) ? {16'd0, wdata[15:0]} * 32'h0001_0001 : wdata;
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata; in_regf = regf;
        #1;
        check("stall_accept", 32'(stall), 32'd1);
        tick();
        in_valid = 1'b0;
        cyc = 1; acnt = 0; dcnt = 0; nreq = 0; done = 1'b0; phase = 1'b0;
        while (!done && cyc < 50) begin
            if (out_valid) begin
                done = 1'b1;
                check("latency", 32'(cyc), 32'(exp_lat));
                check("out_data", out_data, exp_data);
                check("out_regf", 32'(out_regf), 32'(exp_regf));
                check("out_adel", 32'(out_adel), 32'(!al && !st));
                check("out_ades", 32'(out_ades), 32'(!al && st));
                check("bus_err_clear", 32'(bus_err), 32'd0);
                check("stall_done", 32'(stall), 32'd0);
            end else begin
                check("stall_busy", 32'(stall), 32'd1);
                if (!phase) begin
                    if (bus.d_req) begin
                        if (nreq == 0) begin
                            check("d_wr", 32'(bus.d_wr), 32'(st));
                            check("d_size", 32'(bus.d_size), (n == 1) ? 32'd0 : (n == 2) ? 32'd1 : 32'd2);
                            check("d_addr", bus.d_addr, addr);
                            check("d_wdata", bus.d_wdata, exp_wd);
                        end
                        nreq++;
                        bus.d_addr_ok = (acnt == aw);
                        acnt++;
                    end
                end else begin
                    check("req_dropped", 32'(bus.d_req), 32'd0);
                    bus.d_data_ok = (dcnt == dw);
                    bus.d_rdata   = (dcnt == dw) ? rdata : $urandom;
                    dcnt++;
                end
                tick();
                if (bus.d_addr_ok) phase = 1'b1;
                bus.d_addr_ok = 1'b0;
                bus.d_data_ok = 1'b0;
                cyc++;
            end
        end
        check("completed", 32'(done), 32'd1);
        check("req_count", 32'(nreq), al ? 32'(aw + 1) : 32'd0);
        tick();
        check("valid_one_cycle", 32'(out_valid), 32'd0);
        check("idle_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        int cyc, nreq, nv;
        mem_op_t op;
        logic [31:0] addr;
        bus.d_addr_ok = 1'b0;
        bus.d_data_ok = 1'b0;
        bus.d_rdata   = '0;

        tick();
        tick();
        in_valid = 1'b1;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_req", 32'(bus.d_req), 32'd0);
        check("rst_data", out_data, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        run_op(OP_LB, 32'h0000_1003, 32'd0, 5'd7, 0, 0, 32'h80FF_FF7F);
        run_op(OP_SH, 32'h0000_2002, 32'h0000_BEEF, 5'd9, 0, 0, 32'h1234_5678);
        run_op(OP_LW, 32'h0000_3001, 32'd0, 5'd3, 0, 0, 32'hDEAD_BEEF);
        run_op(OP_LHU, 32'h0000_3006, 32'd0, 5'd4, 1, 2, 32'h8765_4321);
        run_op(OP_SW, 32'h0000_3002, 32'hCAFE_F00D, 5'd5, 0, 0, 32'd0);
        run_op(OP_LH, 32'h0000_3001, 32'd0, 5'd6, 0, 0, 32'd0);

        // Address phase never acknowledged: timeout after four ADDR cycles.
        in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h0000_4000; in_regf = 5'd2;
        tick();
        in_valid = 1'b0;
        cyc = 1; nreq = 0;
        while (!out_valid && cyc < 20) begin
            nreq += int'(bus.d_req);
            tick();
            cyc++;
        end
        check("to_valid", 32'(out_valid), 32'd1);
        check("to_cycle", 32'(cyc), 32'd5);
        check("to_req_cycles", 32'(nreq), 32'd4);
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_data", out_data, 32'd0);
        tick();
        check("to_idle_valid", 32'(out_valid), 32'd0);
        check("to_idle_req", 32'(bus.d_req), 32'd0);

        // Flush while the address phase is pending.
        in_valid = 1'b1; in_op = OP_SW; in_addr = 32'h0000_5000; in_wdata = 32'h0102_0304;
        tick();
        in_valid = 1'b0;
        check("fa_req", 32'(bus.d_req), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fa_req_drop", 32'(bus.d_req), 32'd0);
        check("fa_stall", 32'(stall), 32'd0);
        nv = int'(out_valid);
        repeat (3) begin
            tick();
            nv += int'(out_valid);
        end
        check("fa_no_valid", 32'(nv), 32'd0);

        // Flush in the data phase: stall holds until the bus drains three cycles later.
        in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h0000_6000;
        tick();
        in_valid = 1'b0;
        bus.d_addr_ok = 1'b1;
        tick();
        bus.d_addr_ok = 1'b0;
        flush = 1'b1;
        nv = 0;
        for (int c = 2; c <= 5; c++) begin
            check("fd_stall", 32'(stall), 32'd1);
            nv += int'(out_valid);
            bus.d_data_ok = (c == 5);
            bus.d_rdata   = $urandom;
            tick();
            flush = 1'b0;
        end
        bus.d_data_ok = 1'b0;
        check("fd_release", 32'(stall), 32'd0);
        nv += int'(out_valid);
        bus.d_data_ok = 1'b1;
        tick();
        bus.d_data_ok = 1'b0;
        nv += int'(out_valid);
        tick();
        nv += int'(out_valid);
        check("fd_no_valid", 32'(nv), 32'd0);
        check("idle_data_ok_ignored", 32'(stall), 32'd0);

        // Asynchronous reset in the middle of the address phase.
        in_valid = 1'b1; in_op = OP_SW; in_addr = 32'h0000_7000; in_wdata = 32'h1234_5678;
        tick();
        check("ar_req_before", 32'(bus.d_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req", 32'(bus.d_req), 32'd0);
        check("ar_stall", 32'(stall), 32'd0);
        check("ar_addr", bus.d_addr, 32'd0);
        check("ar_wdata", bus.d_wdata, 32'd0);
        check("ar_wr", 32'(bus.d_wr), 32'd0);
        check("ar_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_op(OP_LBU, 32'h0000_8002, 32'd0, 5'd11, 0, 1, 32'h00AB_0000);

        for (int k = 0; k < 40; k++) begin
            op = mem_op_t'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(op_bytes(op) - 1);
            run_op(op, addr, $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
